// File: rtl/countdown_pkg.sv
// Shared types for the round-start countdown: FSM state encoding, sprite select codes
// and the frame-counter width helper.
package countdown_pkg;

  typedef enum logic [2:0] {IDLE, CNT3, CNT2, CNT1, FIGHT} cd_state_t;

  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_3     = 3'd1;
  localparam logic [2:0] SEL_2     = 3'd2;
  localparam logic [2:0] SEL_1     = 3'd3;
  localparam logic [2:0] SEL_FIGHT = 3'd4;

  // Counter holds values up to max(a,b)-1; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/countdown_sequencer_if.sv
// Scan-position inputs and sprite-control outputs of the countdown sequencer.
// The pause signal exists only when COUNTDOWN_PAUSE_EN is defined.
interface countdown_sequencer_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       start;
`ifdef COUNTDOWN_PAUSE_EN
  logic       pause;
`endif
  logic [2:0] sprite_sel;
  logic       sprite_on;
  logic [9:0] spr_x;
  logic [9:0] spr_y;
  logic       fight_start;
  logic       busy;

  modport master (
    output DrawX, DrawY, start,
`ifdef COUNTDOWN_PAUSE_EN
    output pause,
`endif
    input  sprite_sel, sprite_on, spr_x, spr_y, fight_start, busy
  );

  modport slave (
    input  DrawX, DrawY, start,
`ifdef COUNTDOWN_PAUSE_EN
    input  pause,
`endif
    output sprite_sel, sprite_on, spr_x, spr_y, fight_start, busy
  );
endinterface

// File: rtl/countdown_frame_timer.sv
// Loadable frame down-counter; load beats tick, and the count saturates at zero.
module countdown_frame_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             tick_i,
  input  logic             pause_i,
  output logic             zero_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (tick_i && !pause_i && cnt_q != '0)
      cnt_d = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/countdown_sequencer.sv
// Round-start countdown: steps 3 -> 2 -> 1 -> FIGHT on VGA frame ticks and drives the
// overlay sprite select and window-local coordinates. Optional pause: COUNTDOWN_PAUSE_EN.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 60,
  parameter int FIGHT_FRAMES    = 45,
  parameter int WIN_X0          = 192,
  parameter int WIN_Y0          = 112,
  parameter int WIN_W           = 256,
  parameter int WIN_H           = 256
) (
  input  logic                  vga_clk,
  input  logic                  reset,
  countdown_sequencer_if.slave  bus
);
  localparam int CNT_W = cnt_width(FRAMES_PER_STEP, FIGHT_FRAMES);
  localparam logic [CNT_W-1:0] STEP_LOAD  = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] FIGHT_LOAD = CNT_W'(FIGHT_FRAMES - 1);

  cd_state_t        state_q, state_d;
  logic             frame_tick, paused, step, zero;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [2:0]       sel_q, sel_d;
  logic             busy_q, busy_d, fs_q, fs_d, on_q, on_d;
  logic [9:0]       spx_q, spx_d, spy_q, spy_d;
  logic [10:0]      x11, y11;
  logic             in_win;

  assign frame_tick = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);
`ifdef COUNTDOWN_PAUSE_EN
  assign paused = bus.pause;
`else
  assign paused = 1'b0;
`endif
  assign step = frame_tick && !paused;

  countdown_frame_timer #(.WIDTH(CNT_W)) u_timer (
    .clk_i      (vga_clk),
    .rst_i      (reset),
    .load_i     (load),
    .load_val_i (load_val),
    .tick_i     (frame_tick && (state_q != IDLE)),
    .pause_i    (paused),
    .zero_o     (zero)
  );

  // Advancing takes a tick that lands on an already-zero count, so each step spans N ticks.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = STEP_LOAD;
    case (state_q)
      IDLE:  if (bus.start)    begin state_d = CNT3;  load = 1'b1; end
      CNT3:  if (step && zero) begin state_d = CNT2;  load = 1'b1; end
      CNT2:  if (step && zero) begin state_d = CNT1;  load = 1'b1; end
      CNT1:  if (step && zero) begin state_d = FIGHT; load = 1'b1; load_val = FIGHT_LOAD; end
      FIGHT: if (step && zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d = SEL_NONE;
    case (state_d)
      CNT3:    sel_d = SEL_3;
      CNT2:    sel_d = SEL_2;
      CNT1:    sel_d = SEL_1;
      FIGHT:   sel_d = SEL_FIGHT;
      default: sel_d = SEL_NONE;
    endcase
    busy_d = (state_d != IDLE);
    fs_d   = (state_q == CNT1) && (state_d == FIGHT);
  end

  // 11-bit compares keep WIN_X0+WIN_W from wrapping the 10-bit scan range.
  always_comb begin
    x11    = {1'b0, bus.DrawX};
    y11    = {1'b0, bus.DrawY};
    in_win = (x11 >= 11'(WIN_X0)) && (x11 < 11'(WIN_X0 + WIN_W)) &&
             (y11 >= 11'(WIN_Y0)) && (y11 < 11'(WIN_Y0 + WIN_H));
    spx_d  = in_win ? (bus.DrawX - 10'(WIN_X0)) : 10'd0;
    spy_d  = in_win ? (bus.DrawY - 10'(WIN_Y0)) : 10'd0;
    on_d   = in_win && (sel_d != SEL_NONE);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= SEL_NONE;
      busy_q  <= 1'b0;
      fs_q    <= 1'b0;
      on_q    <= 1'b0;
      spx_q   <= 10'd0;
      spy_q   <= 10'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      fs_q    <= fs_d;
      on_q    <= on_d;
      spx_q   <= spx_d;
      spy_q   <= spy_d;
    end
  end

  assign bus.sprite_sel  = sel_q;
  assign bus.sprite_on   = on_q;
  assign bus.spr_x       = spx_q;
  assign bus.spr_y       = spy_q;
  assign bus.fight_start = fs_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with FRAMES_PER_STEP=2, FIGHT_FRAMES=1.
// Frame ticks are produced by driving DrawX=DrawY=0 for one cycle.
module tb_countdown_sequencer;
  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  int   tests   = 0;
  int   failed  = 0;

  countdown_sequencer_if bus();

  countdown_sequencer #(
    .FRAMES_PER_STEP (2),
    .FIGHT_FRAMES    (1)
  ) dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic st;
    int   x, y;
    int   sel, busy, fs, on, sx, sy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input int x, input int y, input int sel,
                              input int busy, input int fs, input int on, input int sx, input int sy);
    vec_t v;
    v.st = st; v.x = x; v.y = y;
    v.sel = sel; v.busy = busy; v.fs = fs; v.on = on; v.sx = sx; v.sy = sy;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge pass, sample just after it.
  task automatic drive(input logic st, input int x, input int y);
    bus.start = st;
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    @(posedge vga_clk);
    #1;
  endtask

  task automatic tick();
    drive(1'b0, 0, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.DrawX = 10'd200;
    bus.DrawY = 10'd120;
`ifdef COUNTDOWN_PAUSE_EN
    bus.pause = 1'b0;
`endif
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst sel",  int'(bus.sprite_sel), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst on",   int'(bus.sprite_on), 0);
    chk("rst sx",   int'(bus.spr_x), 0);
    chk("rst sy",   int'(bus.spr_y), 0);
    chk("rst fs",   int'(bus.fight_start), 0);
    reset = 1'b0;

    //            st  x    y    sel busy fs on sx   sy
    // idle frames: window coords tracked, sprite_on gated off
    tbl.push_back(mk(0, 0,   0,   0, 0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 200, 120, 0, 0, 0, 0, 8,   8));
    tbl.push_back(mk(0, 0,   0,   0, 0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 447, 367, 0, 0, 0, 0, 255, 255));
    tbl.push_back(mk(0, 0,   0,   0, 0, 0, 0, 0,   0));
    // start pulse, window edges while in CNT3
    tbl.push_back(mk(1, 5,   5,   1, 1, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,   0,   1, 1, 0, 0, 0,   0));
    tbl.push_back(mk(0, 192, 112, 1, 1, 0, 1, 0,   0));
    tbl.push_back(mk(0, 448, 112, 1, 1, 0, 0, 0,   0));
    tbl.push_back(mk(0, 447, 367, 1, 1, 0, 1, 255, 255));
    tbl.push_back(mk(0, 191, 200, 1, 1, 0, 0, 0,   0));
    tbl.push_back(mk(0, 300, 368, 1, 1, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,   0,   2, 1, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,   0,   2, 1, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,   0,   3, 1, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,   0,   3, 1, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,   0,   4, 1, 1, 0, 0,   0));
    tbl.push_back(mk(0, 320, 240, 4, 1, 0, 1, 128, 128));
    tbl.push_back(mk(0, 0,   0,   0, 0, 0, 0, 0,   0));
    // start held: start+tick in IDLE does not count the tick; no restart until IDLE
    tbl.push_back(mk(1, 0,   0,   1, 1, 0, 0, 0,   0));
    tbl.push_back(mk(1, 0,   0,   1, 1, 0, 0, 0,   0));
    tbl.push_back(mk(1, 0,   0,   2, 1, 0, 0, 0,   0));
    tbl.push_back(mk(1, 0,   0,   2, 1, 0, 0, 0,   0));
    tbl.push_back(mk(1, 0,   0,   3, 1, 0, 0, 0,   0));
    tbl.push_back(mk(1, 0,   0,   3, 1, 0, 0, 0,   0));
    tbl.push_back(mk(1, 0,   0,   4, 1, 1, 0, 0,   0));
    tbl.push_back(mk(1, 0,   0,   0, 0, 0, 0, 0,   0));
    tbl.push_back(mk(1, 0,   0,   1, 1, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,   0,   1, 1, 0, 0, 0,   0));

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].x, tbl[i].y);
      chk($sformatf("v%0d sel", i),  int'(bus.sprite_sel),  tbl[i].sel);
      chk($sformatf("v%0d busy", i), int'(bus.busy),        tbl[i].busy);
      chk($sformatf("v%0d fs", i),   int'(bus.fight_start), tbl[i].fs);
      chk($sformatf("v%0d on", i),   int'(bus.sprite_on),   tbl[i].on);
      chk($sformatf("v%0d sx", i),   int'(bus.spr_x),       tbl[i].sx);
      chk($sformatf("v%0d sy", i),   int'(bus.spr_y),       tbl[i].sy);
    end

    // Reset during CNT2 aborts without a fight_start
    tick();
    chk("cnt2 sel", int'(bus.sprite_sel), 2);
    reset = 1'b1;
    tick();
    chk("abort sel",  int'(bus.sprite_sel), 0);
    chk("abort busy", int'(bus.busy), 0);
    chk("abort fs",   int'(bus.fight_start), 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post-abort fs %0d", k),  int'(bus.fight_start), 0);
      chk($sformatf("post-abort sel %0d", k), int'(bus.sprite_sel), 0);
    end

`ifdef COUNTDOWN_PAUSE_EN
    // Pause in CNT1 freezes the step; two more ticks after release reach FIGHT
    drive(1'b1, 5, 5);
    chk("p start", int'(bus.sprite_sel), 1);
    tick(); tick(); tick(); tick();
    chk("p cnt1", int'(bus.sprite_sel), 3);
    bus.pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("paused sel %0d", k), int'(bus.sprite_sel), 3);
      chk($sformatf("paused fs %0d", k),  int'(bus.fight_start), 0);
    end
    drive(1'b0, 320, 240);
    chk("paused on", int'(bus.sprite_on), 1);
    bus.pause = 1'b0;
    tick();
    chk("resume 1 sel", int'(bus.sprite_sel), 3);
    tick();
    chk("resume 2 sel", int'(bus.sprite_sel), 4);
    chk("resume 2 fs",  int'(bus.fight_start), 1);
    tick();
    chk("p idle", int'(bus.sprite_sel), 0);
    bus.pause = 1'b1;
    drive(1'b1, 5, 5);
    chk("paused start", int'(bus.sprite_sel), 1);
    bus.pause = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
